// File: rtl/hms_cntdw_ctrl.sv
// hms_cntdw_ctrl: HH:MM:SS countdown timer controller with set mode, pause, done pulse and timed alarm
module hms_cntdw_ctrl #(
   parameter int SEC_MAX   = 59,
   parameter int MIN_MAX   = 59,
   parameter int HOUR_MAX  = 23,
   parameter int ALARM_LEN = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_tick,
   input  logic       i_sw_start,
   input  logic       i_sw_reset,
   input  logic       i_sw_set,
   input  logic       i_sw_inc,
   input  logic       i_alarm_en,
   output logic [5:0] o_sec,
   output logic [5:0] o_min,
   output logic [4:0] o_hour,
   output logic [1:0] o_state,
   output logic [1:0] o_set_sel,
   output logic       o_done,
   output logic       o_alarm
);
   localparam int ACW = $clog2(ALARM_LEN + 1);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SET = 2'd1, S_RUN = 2'd2, S_PAUSE = 2'd3} state_t;
   state_t         r_state, w_state;
   logic [5:0]     r_sec, w_sec, r_min, w_min;
   logic [4:0]     r_hour, w_hour;
   logic [1:0]     r_sel, w_sel;
   logic           r_done, w_done, r_alarm, w_alarm;
   logic [ACW-1:0] r_acnt, w_acnt;
   logic           w_clr, w_last, w_nz;
   // next-state, count and alarm logic; a switch pulse that silences the alarm does nothing else
   always_comb begin
      w_state = r_state;
      w_sec   = r_sec;
      w_min   = r_min;
      w_hour  = r_hour;
      w_sel   = r_sel;
      w_done  = 1'b0;
      w_alarm = r_alarm;
      w_acnt  = r_acnt;
      w_clr   = r_alarm & (~i_alarm_en | i_sw_start | i_sw_set | i_sw_reset);
      w_nz    = (r_sec != '0) || (r_min != '0) || (r_hour != '0);
      w_last  = (r_sec == 6'd1) && (r_min == '0) && (r_hour == '0);
      if (i_sw_reset) begin
         w_state = S_IDLE;
         w_sec   = '0;
         w_min   = '0;
         w_hour  = '0;
         w_sel   = '0;
         w_alarm = 1'b0;
         w_acnt  = '0;
      end else if (w_clr) begin
         w_alarm = 1'b0;
      end else begin
         if (r_alarm && i_tick) begin
            w_acnt  = r_acnt + 1'b1;
            w_alarm = (w_acnt != ACW'(ALARM_LEN));
         end
         case (r_state)
            S_IDLE: begin
               if (i_sw_start)
                  w_state = w_nz ? S_RUN : S_IDLE;
               else if (i_sw_set) begin
                  w_state = S_SET;
                  w_sel   = 2'd1;
               end
            end
            S_SET: begin
               if (i_sw_set) begin
                  w_sel   = (r_sel == 2'd3) ? 2'd0 : r_sel + 2'd1;
                  w_state = (r_sel == 2'd3) ? S_IDLE : S_SET;
               end else if (i_sw_inc) begin
                  if (r_sel == 2'd1) w_sec  = (r_sec  == 6'(SEC_MAX))  ? '0 : r_sec  + 1'b1;
                  if (r_sel == 2'd2) w_min  = (r_min  == 6'(MIN_MAX))  ? '0 : r_min  + 1'b1;
                  if (r_sel == 2'd3) w_hour = (r_hour == 5'(HOUR_MAX)) ? '0 : r_hour + 1'b1;
               end
            end
            S_RUN: begin
               if (i_sw_start)
                  w_state = S_PAUSE;
               else if (i_tick) begin
                  if (r_sec != '0)
                     w_sec = r_sec - 1'b1;
                  else if (r_min != '0) begin
                     w_sec = 6'(SEC_MAX);
                     w_min = r_min - 1'b1;
                  end else if (r_hour != '0) begin
                     w_sec  = 6'(SEC_MAX);
                     w_min  = 6'(MIN_MAX);
                     w_hour = r_hour - 1'b1;
                  end
                  if (w_last) begin
                     w_state = S_IDLE;
                     w_done  = 1'b1;
                     w_alarm = i_alarm_en;
                     w_acnt  = '0;
                  end
               end
            end
            default: begin
               if (i_sw_start) w_state = S_RUN;
            end
         endcase
      end
   end
   // state and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_sec   <= '0;
         r_min   <= '0;
         r_hour  <= '0;
         r_sel   <= '0;
         r_done  <= 1'b0;
         r_alarm <= 1'b0;
         r_acnt  <= '0;
      end else begin
         r_state <= w_state;
         r_sec   <= w_sec;
         r_min   <= w_min;
         r_hour  <= w_hour;
         r_sel   <= w_sel;
         r_done  <= w_done;
         r_alarm <= w_alarm;
         r_acnt  <= w_acnt;
      end
   end
   assign o_sec     = r_sec;
   assign o_min     = r_min;
   assign o_hour    = r_hour;
   assign o_state   = r_state;
   assign o_set_sel = r_sel;
   assign o_done    = r_done;
   assign o_alarm   = r_alarm;
endmodule
